div_seq: RTL and testbench

//  Multi-cycle sequencer for DIV/DIVU, the long-latency writer of the HI/LO pair.

---
 rtl/div_seq.sv | 162 ++++++++++++++++
 tb/tb_div_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// div_seq: multi-cycle DIV/DIVU sequencer feeding the HI/LO write path.
// A radix-2 restoring divide produces one quotient bit per cycle. The divide
// runs on operand magnitudes, and the signs are applied in a final fix-up step.
// The result is returned as {HI = remainder, LO = quotient}.
// While the divide runs, stall_req_o holds IF/ID/EX frozen.

module div_seq #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic                  signed_i,
   input  logic [DATA_W-1:0]     opdata1_i,
   input  logic [DATA_W-1:0]     opdata2_i,
   input  logic                  annul_i,
   output logic [2*DATA_W-1:0]   result_o,
   output logic                  ready_o,
   output logic                  stall_req_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BYZERO = 2'd1,
      RUN    = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   // Partial remainder; it always stays below the divisor, so DATA_W bits suffice.
   logic [DATA_W-1:0]   rem_q, rem_d;
   // Dividend bits shift out of the top while quotient bits shift in at the
   // bottom. After DATA_W iterations this register holds the quotient.
   logic [DATA_W-1:0]   quo_q, quo_d;
   logic [DATA_W-1:0]   dvs_q, dvs_d;
   logic                negQuo_q, negQuo_d;
   logic                negRem_q, negRem_d;
   logic                ready_q, ready_d;
   logic [2*DATA_W-1:0] result_q, result_d;

   logic                dvdNeg;
   logic                dvsNeg;
   logic [DATA_W-1:0]   dvdMag;
   logic [DATA_W-1:0]   dvsMag;
   logic [DATA_W:0]     shifted;
   logic [DATA_W:0]     diff;
   logic                borrow;
   logic [DATA_W-1:0]   remNext;
   logic [DATA_W-1:0]   quoNext;
   logic                lastIter;

   // Operand magnitudes and the one-bit restoring step for the current iteration.
   always_comb begin
      dvdNeg   = signed_i & opdata1_i[DATA_W-1];
      dvsNeg   = signed_i & opdata2_i[DATA_W-1];
      dvdMag   = dvdNeg ? (~opdata1_i + 1'b1) : opdata1_i;
      dvsMag   = dvsNeg ? (~opdata2_i + 1'b1) : opdata2_i;
      shifted  = {rem_q, quo_q[DATA_W-1]};
      diff     = shifted - {1'b0, dvs_q};
      borrow   = diff[DATA_W];
      remNext  = borrow ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
      quoNext  = {quo_q[DATA_W-2:0], ~borrow};
      lastIter = (cnt_q == CNT_W'(DATA_W - 1));
   end

   // Next-state logic for the sequencer, the datapath registers and the registered outputs.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvs_d    = dvs_q;
      negQuo_d = negQuo_q;
      negRem_d = negRem_q;
      ready_d  = 1'b0;
      result_d = '0;

      case (state_q)
         IDLE: begin
            if (start_i && !annul_i) begin
               if (opdata2_i == '0) begin
                  state_d = BYZERO;
               end else begin
                  state_d  = RUN;
                  cnt_d    = '0;
                  rem_d    = '0;
                  quo_d    = dvdMag;
                  dvs_d    = dvsMag;
                  negQuo_d = dvdNeg ^ dvsNeg;
                  negRem_d = dvdNeg;
               end
            end
         end
         BYZERO: begin
            state_d = DONE;
            rem_d   = '0;
            quo_d   = '0;
         end
         RUN: begin
            cnt_d = cnt_q + CNT_W'(1);
            rem_d = remNext;
            quo_d = quoNext;
            if (lastIter) begin
               state_d = DONE;
               quo_d   = negQuo_q ? (~quoNext + 1'b1) : quoNext;
               rem_d   = negRem_q ? (~remNext + 1'b1) : remNext;
            end
         end
         DONE: begin
            if (start_i) begin
               ready_d  = 1'b1;
               result_d = {rem_q, quo_q};
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A flush abandons any divide in flight, and it also overrides a start request.
      if (annul_i && (state_q != IDLE)) begin
         state_d  = IDLE;
         cnt_d    = '0;
         ready_d  = 1'b0;
         result_d = '0;
      end
   end

   // State and datapath registers; reset returns to IDLE even in the middle of a divide.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         negQuo_q <= 1'b0;
         negRem_q <= 1'b0;
         ready_q  <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvs_q    <= dvs_d;
         negQuo_q <= negQuo_d;
         negRem_q <= negRem_d;
         ready_q  <= ready_d;
         result_q <= result_d;
      end
   end

   assign result_o    = result_q;
   assign ready_o     = ready_q;
   assign stall_req_o = start_i & ~ready_q;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: self-checking bench for div_seq.
// Expected values come from plain 64-bit integer division in the reference model.

module tb_div_seq;

   logic        clk;
   logic        rst;
   logic        startIn;
   logic        signedIn;
   logic [31:0] opA;
   logic [31:0] opB;
   logic        annulIn;
   logic [63:0] resultOut;
   logic        readyOut;
   logic        stallOut;

   int checkCount;
   int errorCount;

   div_seq #(.DATA_W(32), .CNT_W(6)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_i     (startIn),
      .signed_i    (signedIn),
      .opdata1_i   (opA),
      .opdata2_i   (opB),
      .annul_i     (annulIn),
      .result_o    (resultOut),
      .ready_o     (readyOut),
      .stall_req_o (stallOut)
   );

   // Free-running clock with a period of 10 time units.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Guard against a hung simulation.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // Count one comparison and report it if the observed value differs from the expected one.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Reference model: {remainder, quotient}, with 0 returned for a zero divisor.
   function automatic logic [63:0] refDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      longint sa;
      longint sb;
      longint q;
      longint r;
      longint unsigned ua;
      longint unsigned ub;
      longint unsigned uq;
      longint unsigned ur;
      if (b == 32'd0) return 64'd0;
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = sa / sb;
         r  = sa % sb;
         return {r[31:0], q[31:0]};
      end
      ua = {32'd0, a};
      ub = {32'd0, b};
      uq = ua / ub;
      ur = ua % ub;
      return {ur[31:0], uq[31:0]};
   endfunction

   // Run one divide: an optional cycle lead with annul held high, a latency
   // check, a hold check in DONE, and a check that the outputs return to 0.
   task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                input int holdCycles, input int annulLead);
      logic [63:0] expected;
      int          lat;
      int          seen;
      expected = refDiv(sgn, a, b);
      lat      = (b == 32'd0) ? 2 : 33;
      @(negedge clk);
      startIn  = 1'b1;
      signedIn = sgn;
      opA      = a;
      opB      = b;
      annulIn  = (annulLead > 0);
      #1;
      checkOutput("stallAtStart", {63'd0, stallOut}, 64'd1);
      for (int i = 0; i < annulLead; i++) @(negedge clk);
      annulIn = 1'b0;
      seen = -1;
      for (int e = 0; e <= lat + 4 && seen < 0; e++) begin
         @(negedge clk);
         if (e == 0) begin
            opA      = $urandom;
            opB      = $urandom;
            signedIn = 1'($urandom);
         end
         if (readyOut) seen = e;
      end
      checkOutput("latency", 64'(seen), 64'(lat));
      if (seen >= 0) begin
         checkOutput("result", resultOut, expected);
         checkOutput("stallAtReady", {63'd0, stallOut}, 64'd0);
         for (int h = 0; h < holdCycles; h++) begin
            @(negedge clk);
            checkOutput("holdResult", resultOut, expected);
         end
      end
      startIn = 1'b0;
      @(negedge clk);
      checkOutput("readyAfterDrop", {63'd0, readyOut}, 64'd0);
      checkOutput("resultAfterDrop", resultOut, 64'd0);
   endtask

   initial begin
      int readyHigh;
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rs;
      checkCount = 0;
      errorCount = 0;
      rst      = 1'b1;
      startIn  = 1'b0;
      signedIn = 1'b0;
      opA      = '0;
      opB      = '0;
      annulIn  = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("resetReady", {63'd0, readyOut}, 64'd0);
      checkOutput("resetResult", resultOut, 64'd0);
      checkOutput("resetStall", {63'd0, stallOut}, 64'd0);
      rst = 1'b0;

      $display("[TB] directed divides");
      applyStimulus(1'b0, 32'd100, 32'd7, 0, 0);
      applyStimulus(1'b1, 32'hFFFFFFF9, 32'd2, 0, 0);
      applyStimulus(1'b1, 32'd7, 32'hFFFFFFFE, 0, 0);
      applyStimulus(1'b1, 32'h80000000, 32'hFFFFFFFF, 0, 0);
      applyStimulus(1'b0, 32'h80000000, 32'hFFFFFFFF, 0, 0);
      applyStimulus(1'b0, 32'd1234, 32'd0, 0, 0);
      applyStimulus(1'b1, 32'hFFFFFF00, 32'd0, 0, 0);
      applyStimulus(1'b0, 32'hDEADBEEF, 32'd16, 5, 0);
      applyStimulus(1'b1, 32'd50, 32'd5, 0, 3);

      $display("[TB] annul in the middle of a divide");
      @(negedge clk);
      startIn  = 1'b1;
      signedIn = 1'b0;
      opA      = 32'd12345;
      opB      = 32'd7;
      repeat (11) @(negedge clk);
      annulIn = 1'b1;
      startIn = 1'b0;
      @(negedge clk);
      annulIn = 1'b0;
      checkOutput("annulReady", {63'd0, readyOut}, 64'd0);
      checkOutput("annulResult", resultOut, 64'd0);
      readyHigh = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (readyOut) readyHigh++;
      end
      checkOutput("annulNoResult", 64'(readyHigh), 64'd0);
      applyStimulus(1'b0, 32'd9, 32'd3, 0, 0);

      $display("[TB] reset in the middle of a divide");
      @(negedge clk);
      startIn  = 1'b1;
      signedIn = 1'b1;
      opA      = 32'hFFFFFC18;
      opB      = 32'd3;
      repeat (15) @(negedge clk);
      rst     = 1'b1;
      startIn = 1'b0;
      @(negedge clk);
      checkOutput("midResetReady", {63'd0, readyOut}, 64'd0);
      checkOutput("midResetResult", resultOut, 64'd0);
      rst = 1'b0;
      applyStimulus(1'b1, 32'hFFFFFC18, 32'd3, 0, 0);

      $display("[TB] random divides");
      for (int n = 0; n < 30; n++) begin
         rs = 1'($urandom);
         ra = $urandom;
         case ($urandom_range(0, 5))
            0:       rb = 32'd0;
            1:       rb = 32'($urandom_range(1, 15));
            2:       rb = 32'hFFFFFFFF;
            default: rb = $urandom;
         endcase
         if ($urandom_range(0, 4) == 0) ra = 32'h80000000;
         applyStimulus(rs, ra, rb, $urandom_range(0, 2), 0);
      end

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
